// File: rtl/maze_pkg.sv
// Shared definitions for the maze cell server: geometry, cell encodings,
// FSM state encoding and the power-on board contents.
package maze_pkg;

    localparam int GRID    = 24;
    localparam int COORD_W = 5;
    localparam int CELL_W  = 3;
    localparam int ADDR_W  = 2 * COORD_W;

    localparam logic [COORD_W-1:0] GRID_LIM = COORD_W'(GRID);
    localparam logic [COORD_W-1:0] GRID_TOP = COORD_W'(GRID - 1);

    typedef enum logic [CELL_W-1:0] {
        OCCUPIED      = 3'd0,
        AVAILABLE     = 3'd1,
        START         = 3'd2,
        END           = 3'd3,
        YOUR_POSITION = 3'd4
    } cell_e;

    typedef enum logic [2:0] {
        CLEAR = 3'd0,
        IDLE  = 3'd1,
        READ  = 3'd2,
        RESP  = 3'd3,
        WACK  = 3'd4
    } state_e;

    // Empty maze: playable area open, start/end corners marked, border blocked.
    function automatic logic [CELL_W-1:0] clear_value(input logic [ADDR_W-1:0] addr);
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        x = addr[COORD_W-1:0];
        y = addr[ADDR_W-1:COORD_W];
        if (x >= GRID_LIM || y >= GRID_LIM)
            return OCCUPIED;
        else if (x == '0 && y == '0)
            return START;
        else if (x == GRID_TOP && y == GRID_TOP)
            return END;
        else
            return AVAILABLE;
    endfunction

endpackage

// File: rtl/maze_ram.sv
// Single-port synchronous cell RAM; read data appears the cycle after the
// address is presented. Contents are deliberately not reset.
module maze_ram #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

    always_ff @(posedge clk) begin
        if (we)
            mem[addr] <= wdata;
        rdata <= mem[addr];
    end

endmodule

// File: rtl/maze_cell_server.sv
// Maze cell server: owns the cell RAM, clears it to an empty board, and
// services single-cell reads and writes through a req/ack handshake.
module maze_cell_server
    import maze_pkg::*;
(
    input  logic               clock,
    input  logic               resetn,
    input  logic               rd_req,
    input  logic [COORD_W-1:0] rd_x,
    input  logic [COORD_W-1:0] rd_y,
    output logic               rd_ack,
    output logic [CELL_W-1:0]  rd_data,
    output logic               rd_oob,
    input  logic               wr_req,
    input  logic [COORD_W-1:0] wr_x,
    input  logic [COORD_W-1:0] wr_y,
    input  logic [CELL_W-1:0]  wr_data,
    output logic               wr_ack,
    input  logic               init_start,
    output logic               init_busy
);

    state_e              state_reg, state_next;
    logic [ADDR_W-1:0]   clr_cnt_reg, clr_cnt_next;
    logic [CELL_W-1:0]   rd_data_reg, rd_data_next;
    logic                rd_oob_reg, rd_oob_next;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [CELL_W-1:0]   ram_wdata;
    logic [CELL_W-1:0]   ram_rdata;
    logic                rd_out_of_grid;

    assign rd_out_of_grid = (rd_x >= GRID_LIM) || (rd_y >= GRID_LIM);

    maze_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (CELL_W)
    ) u_ram (
        .clk   (clock),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            rd_data_reg <= '0;
            rd_oob_reg  <= 1'b0;
        end else begin
            state_reg   <= state_next;
            clr_cnt_reg <= clr_cnt_next;
            rd_data_reg <= rd_data_next;
            rd_oob_reg  <= rd_oob_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        clr_cnt_next = clr_cnt_reg;
        rd_data_next = rd_data_reg;
        rd_oob_next  = rd_oob_reg;
        ram_we       = 1'b0;
        ram_addr     = {rd_y, rd_x};
        ram_wdata    = wr_data;

        unique case (state_reg)
            CLEAR: begin
                ram_we       = 1'b1;
                ram_addr     = clr_cnt_reg;
                ram_wdata    = clear_value(clr_cnt_reg);
                clr_cnt_next = clr_cnt_reg + ADDR_W'(1);
                if (clr_cnt_reg == '1)
                    state_next = IDLE;
            end
            IDLE: begin
                if (init_start) begin
                    clr_cnt_next = '0;
                    state_next   = CLEAR;
                end else if (wr_req) begin
                    ram_we     = 1'b1;
                    ram_addr   = {wr_y, wr_x};
                    state_next = WACK;
                end else if (rd_req) begin
                    // Off-board reads short-circuit the RAM and answer as a wall.
                    if (rd_out_of_grid) begin
                        rd_data_next = OCCUPIED;
                        rd_oob_next  = 1'b1;
                        state_next   = RESP;
                    end else begin
                        state_next = READ;
                    end
                end
            end
            READ: begin
                rd_data_next = ram_rdata;
                rd_oob_next  = 1'b0;
                state_next   = RESP;
            end
            RESP:    state_next = IDLE;
            WACK:    state_next = IDLE;
            default: state_next = CLEAR;
        endcase
    end

    assign rd_ack    = (state_reg == RESP);
    assign wr_ack    = (state_reg == WACK);
    assign init_busy = (state_reg == CLEAR);
    assign rd_data   = rd_data_reg;
    assign rd_oob    = rd_oob_reg;

endmodule

// File: tb/tb_maze_cell_server.sv
// Randomised self-checking bench for maze_cell_server against an array model
// of the board built directly from the cell rules.
module tb_maze_cell_server;
    import maze_pkg::*;

    logic               clock = 1'b0;
    logic               resetn = 1'b0;
    logic               rd_req = 1'b0;
    logic [COORD_W-1:0] rd_x = '0;
    logic [COORD_W-1:0] rd_y = '0;
    logic               rd_ack;
    logic [CELL_W-1:0]  rd_data;
    logic               rd_oob;
    logic               wr_req = 1'b0;
    logic [COORD_W-1:0] wr_x = '0;
    logic [COORD_W-1:0] wr_y = '0;
    logic [CELL_W-1:0]  wr_data = '0;
    logic               wr_ack;
    logic               init_start = 1'b0;
    logic               init_busy;

    int model [0:31][0:31];
    int n_checks = 0;
    int n_pass   = 0;

    always #5 clock = ~clock;

    maze_cell_server dut (
        .clock      (clock),
        .resetn     (resetn),
        .rd_req     (rd_req),
        .rd_x       (rd_x),
        .rd_y       (rd_y),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .rd_oob     (rd_oob),
        .wr_req     (wr_req),
        .wr_x       (wr_x),
        .wr_y       (wr_y),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .init_start (init_start),
        .init_busy  (init_busy)
    );

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp)
            n_pass++;
        else
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic model_init();
        for (int y = 0; y < 32; y++)
            for (int x = 0; x < 32; x++) begin
                if (x >= GRID || y >= GRID)              model[y][x] = 0;
                else if (x == 0 && y == 0)               model[y][x] = 2;
                else if (x == GRID-1 && y == GRID-1)     model[y][x] = 3;
                else                                     model[y][x] = 1;
            end
    endtask

    task automatic wait_clear(input string tag);
        int n = 0;
        while (init_busy && n < 2000) begin
            @(posedge clock); #1;
            n++;
        end
        check($sformatf("%s busy_cycles", tag), n, 1024);
        model_init();
        $display("clear %s: busy for %0d cycles", tag, n);
    endtask

    function automatic bit is_oob(input int x, input int y);
        return (x >= GRID) || (y >= GRID);
    endfunction

    task automatic do_read(input int x, input int y);
        int n = 0;
        @(posedge clock); #1;
        rd_x = COORD_W'(x); rd_y = COORD_W'(y); rd_req = 1'b1;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!rd_ack && n < 20);
        rd_req = 1'b0;
        check($sformatf("rd(%0d,%0d) latency", x, y), n, is_oob(x, y) ? 1 : 2);
        check($sformatf("rd(%0d,%0d) data", x, y), int'(rd_data), is_oob(x, y) ? 0 : model[y][x]);
        check($sformatf("rd(%0d,%0d) oob", x, y), int'(rd_oob), int'(is_oob(x, y)));
        $display("read  (%0d,%0d) -> data=%0d oob=%0d after %0d cycles", x, y, rd_data, rd_oob, n);
    endtask

    task automatic do_write(input int x, input int y, input int d);
        int n = 0;
        @(posedge clock); #1;
        wr_x = COORD_W'(x); wr_y = COORD_W'(y); wr_data = CELL_W'(d); wr_req = 1'b1;
        do begin
            @(posedge clock); #1;
            n++;
        end while (!wr_ack && n < 20);
        wr_req = 1'b0;
        model[y][x] = d;
        check($sformatf("wr(%0d,%0d) latency", x, y), n, 1);
        $display("write (%0d,%0d) <- %0d after %0d cycles", x, y, d, n);
    endtask

    // Read and write raised together: write must be acked first, read after.
    task automatic do_both(input int x, input int y, input int d);
        int n = 0;
        int n_wr = 0;
        @(posedge clock); #1;
        wr_x = COORD_W'(x); wr_y = COORD_W'(y); wr_data = CELL_W'(d); wr_req = 1'b1;
        rd_x = COORD_W'(x); rd_y = COORD_W'(y); rd_req = 1'b1;
        do begin
            @(posedge clock); #1;
            n++;
            check($sformatf("both(%0d,%0d) no early rd_ack", x, y), int'(rd_ack && wr_req), 0);
            if (wr_ack) begin
                n_wr = n;
                wr_req = 1'b0;
                model[y][x] = d;
            end
        end while (!rd_ack && n < 20);
        rd_req = 1'b0;
        check($sformatf("both(%0d,%0d) wr latency", x, y), n_wr, 1);
        check($sformatf("both(%0d,%0d) rd latency", x, y), n, is_oob(x, y) ? 3 : 4);
        check($sformatf("both(%0d,%0d) data", x, y), int'(rd_data), is_oob(x, y) ? 0 : model[y][x]);
        $display("both  (%0d,%0d) <- %0d, read back %0d after %0d cycles", x, y, d, rd_data, n);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int x, y, d, op;
        resetn = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("rst init_busy", int'(init_busy), 1);
        check("rst rd_ack", int'(rd_ack), 0);
        check("rst wr_ack", int'(wr_ack), 0);
        check("rst rd_data", int'(rd_data), 0);
        check("rst rd_oob", int'(rd_oob), 0);
        resetn = 1'b1;
        wait_clear("power-on");

        do_read(0, 0);
        do_read(23, 23);
        do_read(5, 7);
        do_read(24, 3);
        do_read(31, 31);

        do_write(4, 9, 4);
        do_read(4, 9);
        do_both(3, 3, 0);
        do_read(24, 0);

        do_write(1, 1, 5);
        check("hold rd_data", int'(rd_data), 0);
        check("hold rd_oob", int'(rd_oob), 1);
        do_read(1, 1);

        do_write(4, 9, 4);
        @(posedge clock); #1;
        init_start = 1'b1;
        @(posedge clock); #1;
        init_start = 1'b0;
        check("init_start busy", int'(init_busy), 1);
        wait_clear("init_start");
        do_read(4, 9);
        do_read(1, 1);

        for (int i = 0; i < 80; i++) begin
            op = $urandom_range(0, 3);
            x  = ($urandom_range(0, 4) == 0) ? $urandom_range(GRID, 31) : $urandom_range(0, GRID-1);
            y  = ($urandom_range(0, 4) == 0) ? $urandom_range(GRID, 31) : $urandom_range(0, GRID-1);
            d  = $urandom_range(0, 7);
            case (op)
                0, 1: do_read(x, y);
                2:    do_write(x, y, d);
                default: do_both(x, y, d);
            endcase
        end

        @(posedge clock); #1;
        rd_x = 5'd5; rd_y = 5'd5; rd_req = 1'b1;
        @(posedge clock); #1;
        resetn = 1'b0;
        #1;
        check("midread rst init_busy", int'(init_busy), 1);
        check("midread rst rd_ack", int'(rd_ack), 0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clock); #1;
            check($sformatf("midread rst rd_ack cyc%0d", i), int'(rd_ack), 0);
        end
        rd_req = 1'b0;
        resetn = 1'b1;
        wait_clear("mid-read reset");
        do_read(0, 0);
        do_read(4, 9);
        do_read(23, 23);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
